// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: converts a valid/ready request port into single
// (non-burst) AHB-Lite transfers with pipelined address and data phases.
// Each accepted request yields exactly one in-order response strobe.
//
// Request handshake: a request transfers on a rising edge where
// req_valid_i and req_ready_o are both high; req_ready_o depends
// combinationally on hready_i. Responses are a one-cycle strobe with
// no backpressure.
module ahb_lite_master #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [2:0]        req_size_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AWIDTH-1:0] haddr_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [1:0]        htrans_o,
    output logic [2:0]        hburst_o,
    output logic [DWIDTH-1:0] hwdata_o,
    input  logic [DWIDTH-1:0] hrdata_i,
    input  logic              hready_i,
    input  logic              hresp_i
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Address-phase register
    logic              a_valid;
    logic              a_write;
    logic [2:0]        a_size;
    logic [AWIDTH-1:0] a_addr;
    logic [DWIDTH-1:0] a_wdata;

    // Data-phase register
    logic              d_valid;
    logic              d_write;
    logic [DWIDTH-1:0] d_wdata;

    // Set between the two cycles of an ERROR response; blocks new address phases
    logic              err_hold;

    logic              accept;

    assign req_ready_o = !err_hold && (!a_valid || hready_i);
    assign accept      = req_valid_i && req_ready_o;

    assign htrans_o = (a_valid && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_o  = a_addr;
    assign hwrite_o = a_write;
    assign hsize_o  = a_size;
    assign hburst_o = HBURST_SINGLE;
    assign hwdata_o = (d_valid && d_write) ? d_wdata : '0;

    // Address phase: load accepted request, drain when bus advances, hold during error replay
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_size  <= 3'b000;
            a_addr  <= '0;
            a_wdata <= '0;
        end else if (accept) begin
            a_valid <= 1'b1;
            a_write <= req_write_i;
            a_size  <= req_size_i;
            a_addr  <= req_addr_i;
            a_wdata <= req_wdata_i;
        end else if (hready_i && !err_hold) begin
            a_valid <= 1'b0;
        end
    end

    // Data phase: takes over the address phase whenever the bus advances
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else if (hready_i) begin
            d_valid <= a_valid && !err_hold;
            d_write <= a_write;
            d_wdata <= a_wdata;
        end
    end

    // Error hold: first ERROR cycle sets it, the completing second cycle clears it
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_hold <= 1'b0;
        end else if (hready_i) begin
            err_hold <= 1'b0;
        end else if (d_valid && hresp_i) begin
            err_hold <= 1'b1;
        end
    end

    // Response strobe for the data phase that completes on this edge
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (d_valid && hready_i) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= d_write ? '0 : hrdata_i;
            rsp_err_o   <= hresp_i;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_ahb_lite_master;

    logic        hclk;
    logic        hresetn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [2:0]  req_size_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] haddr_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hburst_o;
    logic [31:0] hwdata_o;
    logic [31:0] hrdata_i;
    logic        hready_i;
    logic        hresp_i;

    int checks = 0;
    int errors = 0;

    ahb_lite_master #(.AWIDTH(32), .DWIDTH(32)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_size_i  (req_size_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .haddr_o     (haddr_o),
        .hwrite_o    (hwrite_o),
        .hsize_o     (hsize_o),
        .htrans_o    (htrans_o),
        .hburst_o    (hburst_o),
        .hwdata_o    (hwdata_o),
        .hrdata_i    (hrdata_i),
        .hready_i    (hready_i),
        .hresp_i     (hresp_i)
    );

    // Clock
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        @(negedge hclk);
    endtask

    task automatic drive_req(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid_i = v;
        req_write_i = w;
        req_size_i  = 3'd2;
        req_addr_i  = a;
        req_wdata_i = d;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        hrdata_i = 32'h0;
        hready_i = 1'b1;
        hresp_i  = 1'b0;
        settle();
        checks++; if (htrans_o !== 2'b00) begin errors++; $display("FAIL rst_htrans got %h exp 0", htrans_o); end
        checks++; if (haddr_o !== 32'h0) begin errors++; $display("FAIL rst_haddr got %h exp 0", haddr_o); end
        checks++; if (hwrite_o !== 1'b0 || hsize_o !== 3'd0 || hburst_o !== 3'd0) begin errors++; $display("FAIL rst_ctrl got w=%b s=%h b=%h exp 0", hwrite_o, hsize_o, hburst_o); end
        checks++; if (hwdata_o !== 32'h0) begin errors++; $display("FAIL rst_hwdata got %h exp 0", hwdata_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL rst_rsp got v=%b d=%h e=%b exp 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        tick();
        tick();
        hresetn = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        // cycle 0: offer read, accepted at end of cycle
        drive_req(1'b1, 1'b0, 32'h1000_0008, 32'h0);
        settle();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rd_ready got %b exp 1", req_ready_o); end
        tick();
        // cycle 1: address phase
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        checks++; if (htrans_o !== 2'b10) begin errors++; $display("FAIL rd_htrans got %h exp 2", htrans_o); end
        checks++; if (haddr_o !== 32'h1000_0008 || hwrite_o !== 1'b0 || hsize_o !== 3'd2) begin errors++; $display("FAIL rd_addr got %h w=%b s=%h exp 10000008 w=0 s=2", haddr_o, hwrite_o, hsize_o); end
        tick();
        // cycle 2: data phase
        hrdata_i = 32'hDEAD_BEEF;
        settle();
        checks++; if (htrans_o !== 2'b00 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd_dphase got htrans=%h rsp=%b exp 0 0", htrans_o, rsp_valid_o); end
        tick();
        // cycle 3: response
        hrdata_i = 32'h0;
        settle();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF || rsp_err_o !== 1'b0) begin errors++; $display("FAIL rd_rsp got v=%b d=%h e=%b exp 1 deadbeef 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        tick();
        settle();
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd_rsp_once got %b exp 0", rsp_valid_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_htrans;
        logic [31:0] exp_hwdata;
        logic        exp_rsp;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive_req(1'b1, 1'b1, 32'(4 * c), 32'(c + 1));
            else       drive_req(1'b0, 1'b0, 32'h0, 32'h0);
            settle();
            exp_htrans = (c >= 1 && c <= 4) ? 2'b10 : 2'b00;
            exp_hwdata = (c >= 2 && c <= 5) ? 32'(c - 1) : 32'h0;
            exp_rsp    = (c >= 3 && c <= 6);
            checks++; if (htrans_o !== exp_htrans) begin errors++; $display("FAIL b2b_htrans c=%0d got %h exp %h", c, htrans_o, exp_htrans); end
            if (exp_htrans == 2'b10) begin
                checks++; if (haddr_o !== 32'(4 * (c - 1)) || hwrite_o !== 1'b1) begin errors++; $display("FAIL b2b_haddr c=%0d got %h w=%b exp %h w=1", c, haddr_o, hwrite_o, 32'(4 * (c - 1))); end
            end
            checks++; if (hwdata_o !== exp_hwdata) begin errors++; $display("FAIL b2b_hwdata c=%0d got %h exp %h", c, hwdata_o, exp_hwdata); end
            checks++; if (rsp_valid_o !== exp_rsp || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL b2b_rsp c=%0d got v=%b d=%h e=%b exp v=%b d=0 e=0", c, rsp_valid_o, rsp_rdata_o, rsp_err_o, exp_rsp); end
            if (c < 4) begin
                checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, req_ready_o); end
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        // cycle 0: write 0x4
        drive_req(1'b1, 1'b1, 32'h4, 32'hAA);
        tick();
        // cycle 1: write in address phase, read 0x8 accepted
        drive_req(1'b1, 1'b0, 32'h8, 32'h0);
        settle();
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h4) begin errors++; $display("FAIL ws_wr_addr got %h %h exp 2 4", htrans_o, haddr_o); end
        tick();
        // cycles 2,3: two wait states on the write data phase
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        hready_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            settle();
            checks++; if (haddr_o !== 32'h8 || htrans_o !== 2'b10 || hwrite_o !== 1'b0) begin errors++; $display("FAIL ws_hold w=%0d got addr=%h t=%h wr=%b exp 8 2 0", w, haddr_o, htrans_o, hwrite_o); end
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL ws_ready w=%0d got %b exp 0", w, req_ready_o); end
            checks++; if (hwdata_o !== 32'hAA || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL ws_data w=%0d got wd=%h rsp=%b exp aa 0", w, hwdata_o, rsp_valid_o); end
            tick();
        end
        // cycle 4: write completes
        hready_i = 1'b1;
        settle();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL ws_ready_rel got %b exp 1", req_ready_o); end
        tick();
        // cycle 5: read data phase; write response
        hrdata_i = 32'h1234_5678;
        settle();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL ws_rsp1 got v=%b d=%h e=%b exp 1 0 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        checks++; if (htrans_o !== 2'b00 || hwdata_o !== 32'h0) begin errors++; $display("FAIL ws_idle got t=%h wd=%h exp 0 0", htrans_o, hwdata_o); end
        tick();
        // cycle 6: read response
        hrdata_i = 32'h0;
        settle();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1234_5678 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL ws_rsp2 got v=%b d=%h e=%b exp 1 12345678 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        tick();
    endtask

    task automatic test_error_replay();
        // cycle 0: read 0x10
        drive_req(1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        // cycle 1: read 0x14 accepted behind it
        drive_req(1'b1, 1'b0, 32'h14, 32'h0);
        tick();
        // cycle 2: first ERROR cycle
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        hresp_i  = 1'b1;
        hready_i = 1'b0;
        settle();
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h14) begin errors++; $display("FAIL err_c1 got t=%h a=%h exp 2 14", htrans_o, haddr_o); end
        tick();
        // cycle 3: second ERROR cycle
        hready_i = 1'b1;
        settle();
        checks++; if (htrans_o !== 2'b00) begin errors++; $display("FAIL err_idle got %h exp 0", htrans_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL err_ready got %b exp 0", req_ready_o); end
        tick();
        // cycle 4: errored response; 0x14 reissued
        hresp_i = 1'b0;
        settle();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL err_rsp got v=%b e=%b exp 1 1", rsp_valid_o, rsp_err_o); end
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h14) begin errors++; $display("FAIL err_replay got t=%h a=%h exp 2 14", htrans_o, haddr_o); end
        tick();
        // cycle 5: replay data phase
        hrdata_i = 32'hCAFE_0014;
        settle();
        checks++; if (rsp_valid_o !== 1'b0 || htrans_o !== 2'b00) begin errors++; $display("FAIL err_gap got v=%b t=%h exp 0 0", rsp_valid_o, htrans_o); end
        tick();
        // cycle 6: replay response
        hrdata_i = 32'h0;
        settle();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hCAFE_0014 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL err_rsp2 got v=%b d=%h e=%b exp 1 cafe0014 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        tick();
    endtask

    task automatic test_single_cycle_error();
        drive_req(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        // data phase: ERROR with hready high
        hresp_i  = 1'b1;
        hrdata_i = 32'h0000_0040;
        tick();
        hresp_i  = 1'b0;
        hrdata_i = 32'h0;
        settle();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h40) begin errors++; $display("FAIL sce_rsp got v=%b e=%b d=%h exp 1 1 40", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL sce_ready got %b exp 1", req_ready_o); end
        tick();
    endtask

    task automatic test_reset_midflight();
        drive_req(1'b1, 1'b1, 32'h20, 32'h55);
        tick();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        // write in data phase, stalled
        hready_i = 1'b0;
        settle();
        checks++; if (hwdata_o !== 32'h55) begin errors++; $display("FAIL mr_pre got %h exp 55", hwdata_o); end
        #2;
        hresetn = 1'b0;
        #1;
        checks++; if (htrans_o !== 2'b00 || haddr_o !== 32'h0 || hwdata_o !== 32'h0 || hwrite_o !== 1'b0) begin errors++; $display("FAIL mr_bus got t=%h a=%h wd=%h w=%b exp 0", htrans_o, haddr_o, hwdata_o, hwrite_o); end
        checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mr_hs got rdy=%b rsp=%b exp 1 0", req_ready_o, rsp_valid_o); end
        hready_i = 1'b1;
        tick();
        tick();
        hresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (rsp_valid_o !== 1'b0 || htrans_o !== 2'b00) begin errors++; $display("FAIL mr_quiet k=%0d got rsp=%b t=%h exp 0 0", k, rsp_valid_o, htrans_o); end
            tick();
        end
        // next request proceeds normally
        drive_req(1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h30) begin errors++; $display("FAIL mr_next_addr got t=%h a=%h exp 2 30", htrans_o, haddr_o); end
        tick();
        hrdata_i = 32'h0BAD_F00D;
        tick();
        hrdata_i = 32'h0;
        settle();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0BAD_F00D || rsp_err_o !== 1'b0) begin errors++; $display("FAIL mr_next_rsp got v=%b d=%h e=%b exp 1 0badf00d 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error_replay();
        test_single_cycle_error();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
